clk_divider_prog: RTL

- Runtime-programmable successor to the fixed-constant clock divider. Serves as the period/timebase generator for the PWM and blink blocks.
- Output period is loaded at run time, WIDTH-parameterised, and applied glitch-free at a period boundary.
- Adds a count enable, a one-cycle tick strobe, a load/ack handshake and a sticky error flag for illegal divisors.

---
 rtl/clk_divider_prog.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider: period loaded via load/ack handshake, applied at a period boundary.
// Optional macro CLKDIV_DUTY_EN adds duty_val_i to program the high time together with the period.
module clk_divider_prog #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 32'd40_000_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_val_i,
    input  logic             div_load_i,
`ifdef CLKDIV_DUTY_EN
    input  logic [WIDTH-1:0] duty_val_i,
`endif
    output logic             div_ack_o,
    output logic             div_pending_o,
    output logic             div_err_o,
    output logic             clk_div_o,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_L = DEF_P >> 1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] per_n_q, per_n_d;
    logic [WIDTH-1:0] low_n_q, low_n_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] load_per;
    logic [WIDTH-1:0] load_low;
    logic             load_bad;
    logic             boundary;
    logic             apply_now;
    logic             apply_pend;

    // Sanitise the requested period (and duty) into a legal low-phase length.
    always_comb begin
        load_per = (div_val_i < TWO) ? TWO : div_val_i;
        load_bad = (div_val_i < TWO);
`ifdef CLKDIV_DUTY_EN
        if (duty_val_i == '0) begin
            load_low = load_per - ONE;
            load_bad = 1'b1;
        end else if (duty_val_i >= load_per) begin
            load_low = ONE;
            load_bad = 1'b1;
        end else begin
            load_low = load_per - duty_val_i;
        end
`else
        load_low = load_per >> 1;
`endif
    end

    always_comb begin
        boundary   = en_i && (cnt_q == per_q - ONE);
        apply_now  = div_load_i && (!en_i || boundary);
        apply_pend = !div_load_i && pend_q && (!en_i || boundary);

        cnt_d   = cnt_q;
        per_d   = per_q;
        low_d   = low_q;
        per_n_d = per_n_q;
        low_n_d = low_n_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        tick_d  = 1'b0;
        err_d   = err_q | (div_load_i & load_bad);
        clk_d   = clk_q;

        if (en_i) begin
            if (boundary) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        // A fresh load wins over an older pending value; with en low it applies at once.
        if (apply_now) begin
            per_d  = load_per;
            low_d  = load_low;
            cnt_d  = '0;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end else if (apply_pend) begin
            per_d  = per_n_q;
            low_d  = low_n_q;
            cnt_d  = '0;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end else if (div_load_i) begin
            per_n_d = load_per;
            low_n_d = load_low;
            pend_d  = 1'b1;
        end

        if (en_i || ack_d) begin
            clk_d = (cnt_d >= low_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            per_q   <= DEF_P;
            low_q   <= DEF_L;
            per_n_q <= DEF_P;
            low_n_q <= DEF_L;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            low_q   <= low_d;
            per_n_q <= per_n_d;
            low_n_q <= low_n_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign div_ack_o     = ack_q;
    assign div_pending_o = pend_q;
    assign div_err_o     = err_q;
    assign clk_div_o     = clk_q;
    assign tick_o        = tick_q;

endmodule
